// File: rtl/decoder_pkg.sv
// Shared operation codes, instruction classes, flag indices and decode helpers.
package decoder_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned FLAG_W = 5;

    localparam int unsigned FLAG_Z  = 4;
    localparam int unsigned FLAG_CY = 3;
    localparam int unsigned FLAG_S  = 2;
    localparam int unsigned FLAG_P  = 1;
    localparam int unsigned FLAG_OV = 0;

    localparam logic [OP_W-1:0] OP_ALU0   = 5'b00000;
    localparam logic [OP_W-1:0] OP_ALU1   = 5'b00100;
    localparam logic [OP_W-1:0] OP_ALU2   = 5'b01000;
    localparam logic [OP_W-1:0] OP_ALU3   = 5'b01100;
    localparam logic [OP_W-1:0] OP_ALU4   = 5'b10000;
    localparam logic [OP_W-1:0] OP_ALU5   = 5'b10100;
    localparam logic [OP_W-1:0] OP_INC    = 5'b00001;
    localparam logic [OP_W-1:0] OP_DEC    = 5'b00101;
    localparam logic [OP_W-1:0] OP_JMP    = 5'b01001;
    localparam logic [OP_W-1:0] OP_CALL   = 5'b01101;
    localparam logic [OP_W-1:0] OP_JZ     = 5'b01010;
    localparam logic [OP_W-1:0] OP_CZ     = 5'b01110;
    localparam logic [OP_W-1:0] OP_JOV    = 5'b01011;
    localparam logic [OP_W-1:0] OP_COV    = 5'b01111;
    localparam logic [OP_W-1:0] OP_JS     = 5'b10010;
    localparam logic [OP_W-1:0] OP_CS     = 5'b10110;
    localparam logic [OP_W-1:0] OP_RET    = 5'b10001;
    localparam logic [OP_W-1:0] OP_LDA0   = 5'b11100;
    localparam logic [OP_W-1:0] OP_LDA1   = 5'b11101;
    localparam logic [OP_W-1:0] OP_LDA2   = 5'b11110;
    localparam logic [OP_W-1:0] OP_STREG  = 5'b11001;
    localparam logic [OP_W-1:0] OP_STMEM  = 5'b11010;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_INCDEC,
        CLS_JUMP,
        CLS_RET,
        CLS_LOADA,
        CLS_STORE,
        CLS_NOP
    } op_class_e;

    typedef struct packed {
        logic       a_ce;
        logic       regs_ce;
        logic       flags_ce;
        logic       load_pc;
        logic       pc_source;
        logic       block_cy_ov;
        logic       mem_we;
        logic [1:0] arg_source;
    } ctrl_t;

    // Map an operation code onto its instruction class.
    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        op_class_e cls;
        case (op)
            OP_ALU0, OP_ALU1, OP_ALU2,
            OP_ALU3, OP_ALU4, OP_ALU5:        cls = CLS_ALU;
            OP_INC, OP_DEC:                   cls = CLS_INCDEC;
            OP_JMP, OP_CALL, OP_JZ, OP_CZ,
            OP_JOV, OP_COV, OP_JS, OP_CS:     cls = CLS_JUMP;
            OP_RET:                           cls = CLS_RET;
            OP_LDA0, OP_LDA1, OP_LDA2:        cls = CLS_LOADA;
            OP_STREG, OP_STMEM:               cls = CLS_STORE;
            default:                          cls = CLS_NOP;
        endcase
        return cls;
    endfunction

    // Whether a jump/call operation is taken under the sampled flags.
    function automatic logic jump_taken(input logic [OP_W-1:0] op,
                                        input logic [FLAG_W-1:0] flags);
        logic taken;
        case (op)
            OP_JMP, OP_CALL: taken = 1'b1;
            OP_JZ,  OP_CZ:   taken = flags[FLAG_Z];
            OP_JOV, OP_COV:  taken = flags[FLAG_OV];
            OP_JS,  OP_CS:   taken = flags[FLAG_S];
            default:         taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/link_stack.sv
// Return-address stack: push/pop of program addresses with full/empty status.
module link_stack #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic              full_c,
    output logic              empty_c,
    output logic [ADDR_W-1:0] top_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]    sp_q, sp_d;
    logic [PTR_W-1:0]  top_idx_c;
    logic [ADDR_W-1:0] mem [DEPTH];

    assign full_c    = (sp_q == (PTR_W+1)'(DEPTH));
    assign empty_c   = (sp_q == '0);
    assign top_idx_c = sp_q[PTR_W-1:0] - PTR_W'(1);
    assign top_c     = mem[top_idx_c];

    // Stack pointer update; a blocked push or pop leaves it unchanged.
    always_comb begin
        sp_d = sp_q;
        if (push && !full_c) begin
            sp_d = sp_q + (PTR_W+1)'(1);
        end else if (pop && !empty_c) begin
            sp_d = sp_q - (PTR_W+1)'(1);
        end
    end

    // Stack pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage; contents are meaningless above the stack pointer.
    always_ff @(posedge clk) begin
        if (push && !full_c) begin
            mem[sp_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pipelined_instruction_decoder.sv
// Registered instruction decoder between fetch and execute with a
// return-address stack and squash of the slot after a taken transfer.
module pipelined_instruction_decoder
    import decoder_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W+4:0]      ins,
    input  logic [ADDR_W-1:0]      ins_addr,
    input  logic [4:0]             flags,
    input  logic                   clr_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   A_ce,
    output logic                   REGS_ce,
    output logic                   flags_ce,
    output logic                   load_pc,
    output logic                   PC_source,
    output logic                   block_cy_ov,
    output logic                   mem_we,
    output logic [1:0]             arg_source,
    output logic [2:0]             opcode,
    output logic [DATA_W-1:0]      instant,
    output logic [ADDR_W-1:0]      new_pc,
    output logic [REG_AW-1:0]      REGS_addr,
    output logic [MEM_AW-1:0]      mem_addr,
    output logic                   stack_ovf,
    output logic                   stack_unf
);

    localparam int unsigned IW = DATA_W + 5;

    logic              out_valid_q, out_valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [2:0]        opcode_q, opcode_d;
    logic [DATA_W-1:0] instant_q, instant_d;
    logic [ADDR_W-1:0] new_pc_q, new_pc_d;
    logic [REG_AW-1:0] regs_addr_q, regs_addr_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              squash_q, squash_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [OP_W-1:0]   op_c;
    op_class_e         cls_c;
    ctrl_t             dec_ctrl_c;
    logic [ADDR_W-1:0] dec_pc_c;
    logic              push_req_c, pop_req_c, ovf_evt_c, unf_evt_c;
    logic              accept_c, take_c;
    logic              stk_full_c, stk_empty_c;
    logic [ADDR_W-1:0] stk_top_c;

    assign in_ready = !out_valid_q || out_ready;
    assign accept_c = in_valid && in_ready;
    assign take_c   = accept_c && !squash_q;
    assign op_c     = ins[IW-1 -: OP_W];
    assign cls_c    = op_class(op_c);

    // Decode the presented instruction into a control bundle and stack requests.
    always_comb begin
        dec_ctrl_c = '0;
        dec_pc_c   = '0;
        push_req_c = 1'b0;
        pop_req_c  = 1'b0;
        ovf_evt_c  = 1'b0;
        unf_evt_c  = 1'b0;
        case (cls_c)
            CLS_ALU: begin
                dec_ctrl_c.a_ce     = 1'b1;
                dec_ctrl_c.flags_ce = 1'b1;
            end
            CLS_INCDEC: begin
                dec_ctrl_c.a_ce        = 1'b1;
                dec_ctrl_c.flags_ce    = 1'b1;
                dec_ctrl_c.arg_source  = 2'b01;
                dec_ctrl_c.block_cy_ov = 1'b1;
            end
            CLS_JUMP: begin
                if (jump_taken(op_c, flags)) begin
                    dec_ctrl_c.load_pc     = 1'b1;
                    dec_ctrl_c.arg_source  = 2'b01;
                    dec_ctrl_c.block_cy_ov = 1'b1;
                    dec_pc_c               = ADDR_W'(ins[DATA_W-1:0]);
                    if (op_c[2]) begin
                        push_req_c = !stk_full_c;
                        ovf_evt_c  = stk_full_c;
                    end
                end
            end
            CLS_RET: begin
                dec_ctrl_c.pc_source = 1'b1;
                if (stk_empty_c) begin
                    unf_evt_c = 1'b1;
                end else begin
                    dec_ctrl_c.load_pc = 1'b1;
                    dec_pc_c           = stk_top_c;
                    pop_req_c          = 1'b1;
                end
            end
            CLS_LOADA: begin
                dec_ctrl_c.a_ce        = 1'b1;
                dec_ctrl_c.pc_source   = 1'b1;
                dec_ctrl_c.block_cy_ov = 1'b1;
                dec_ctrl_c.arg_source  = op_c[1:0];
            end
            CLS_STORE: begin
                dec_ctrl_c.regs_ce     = op_c[0];
                dec_ctrl_c.mem_we      = op_c[1];
                dec_ctrl_c.pc_source   = 1'b1;
                dec_ctrl_c.arg_source  = 2'b01;
                dec_ctrl_c.block_cy_ov = 1'b1;
            end
            default: begin
                dec_ctrl_c = '0;
            end
        endcase
    end

    link_stack #(
        .DEPTH  (STACK_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_link_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (take_c && push_req_c),
        .pop       (take_c && pop_req_c),
        .push_data (ins_addr + ADDR_W'(1)),
        .full_c    (stk_full_c),
        .empty_c   (stk_empty_c),
        .top_c     (stk_top_c)
    );

    // Next-state: load on a taken accept, drain on consume, hold on stall.
    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        opcode_d    = opcode_q;
        instant_d   = instant_q;
        new_pc_d    = new_pc_q;
        regs_addr_d = regs_addr_q;
        mem_addr_d  = mem_addr_q;
        squash_d    = squash_q;
        if (take_c) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec_ctrl_c;
            opcode_d    = ins[IW-1 -: 3];
            instant_d   = ins[DATA_W-1:0];
            new_pc_d    = dec_pc_c;
            regs_addr_d = ins[REG_AW-1:0];
            mem_addr_d  = ins[MEM_AW-1:0];
            squash_d    = dec_ctrl_c.load_pc;
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
                ctrl_d      = '0;
            end
            if (accept_c) begin
                squash_d = 1'b0;
            end
        end
        ovf_d = (take_c && ovf_evt_c) || (ovf_q && !clr_err);
        unf_d = (take_c && unf_evt_c) || (unf_q && !clr_err);
    end

    // Pipeline, squash and sticky-error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            opcode_q    <= '0;
            instant_q   <= '0;
            new_pc_q    <= '0;
            regs_addr_q <= '0;
            mem_addr_q  <= '0;
            squash_q    <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            opcode_q    <= opcode_d;
            instant_q   <= instant_d;
            new_pc_q    <= new_pc_d;
            regs_addr_q <= regs_addr_d;
            mem_addr_q  <= mem_addr_d;
            squash_q    <= squash_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign A_ce        = ctrl_q.a_ce;
    assign REGS_ce     = ctrl_q.regs_ce;
    assign flags_ce    = ctrl_q.flags_ce;
    assign load_pc     = ctrl_q.load_pc;
    assign PC_source   = ctrl_q.pc_source;
    assign block_cy_ov = ctrl_q.block_cy_ov;
    assign mem_we      = ctrl_q.mem_we;
    assign arg_source  = ctrl_q.arg_source;
    assign opcode      = opcode_q;
    assign instant     = instant_q;
    assign new_pc      = new_pc_q;
    assign REGS_addr   = regs_addr_q;
    assign mem_addr    = mem_addr_q;
    assign stack_ovf   = ovf_q;
    assign stack_unf   = unf_q;

endmodule
